// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: byte-lane data memory for the RV32 load/store path.
// Serves LB/LH/LW/LBU/LHU and SB/SH/SW through a valid/ready request and a
// one-cycle response pulse. Word-crossing accesses take two internal beats.
// Out-of-range addresses and bad funct codes are answered with rsp_err_o.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_we_i                  1 = store, 0 = load
//   req_funct_i               `FUNC_* code ({funct3, opcode})
//   req_addr_i                byte address (ADDR_W bits)
//   req_wdata_i               store data, LSB-aligned
//   rsp_valid_o               one-cycle response pulse
//   rsp_rdata_o               extended load data, 0 for stores/errors
//   rsp_err_o                 bad address or bad funct
//
// Build option: define MISALIGN_TRAP_EN to reject every access that is not
// naturally aligned instead of splitting word-crossing accesses.
//
// Initial contents: byte i reads i[7:0] for i < 32, 0 elsewhere. The array
// itself stores data XORed with that constant image, so a zero power-up array
// presents the image without any reset of the storage.

`ifndef FUNC_LB
`define FUNC_LB  10'b000_0000011
`endif
`ifndef FUNC_LH
`define FUNC_LH  10'b001_0000011
`endif
`ifndef FUNC_LW
`define FUNC_LW  10'b010_0000011
`endif
`ifndef FUNC_LBU
`define FUNC_LBU 10'b100_0000011
`endif
`ifndef FUNC_LHU
`define FUNC_LHU 10'b101_0000011
`endif
`ifndef FUNC_SB
`define FUNC_SB  10'b000_0100011
`endif
`ifndef FUNC_SH
`define FUNC_SH  10'b001_0100011
`endif
`ifndef FUNC_SW
`define FUNC_SW  10'b010_0100011
`endif

module data_ram_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [9:0]        req_funct_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned MEM_BYTES = 4 * DEPTH_WORDS;

  typedef enum logic {S_IDLE, S_BEAT2} state_e;

  // Constant power-up image overlaid on the storage array.
  function automatic logic [31:0] image_word(input logic [IDX_W-1:0] idx);
    logic [31:0] w;
    int unsigned base;
    w    = '0;
    base = 4 * 32'(idx);
    if (32'(idx) < 32'd8) begin
      for (int unsigned b = 0; b < 4; b++) w[8*b +: 8] = 8'(base + b);
    end
    return w;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] sz,
                                         input logic sx);
    if (sz == 3'd1) return {{24{sx & raw[7]}}, raw[7:0]};
    if (sz == 3'd2) return {{16{sx & raw[15]}}, raw[15:0]};
    return raw;
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        sz_q, sz_d;
  logic              sx_q, sx_d;
  logic              we_q, we_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       hi_wdata_q, hi_wdata_d;
  logic [3:0]        hi_be_q, hi_be_d;

  // Funct decode: size in bytes (0 = unknown), sign-extend, store.
  logic [2:0] dec_sz;
  logic       dec_sx;
  logic       dec_st;

  always_comb begin
    dec_sz = 3'd0;
    dec_sx = 1'b0;
    dec_st = 1'b0;
    case (req_funct_i)
      `FUNC_LB:  begin dec_sz = 3'd1; dec_sx = 1'b1; end
      `FUNC_LH:  begin dec_sz = 3'd2; dec_sx = 1'b1; end
      `FUNC_LW:  dec_sz = 3'd4;
      `FUNC_LBU: dec_sz = 3'd1;
      `FUNC_LHU: dec_sz = 3'd2;
      `FUNC_SB:  begin dec_sz = 3'd1; dec_st = 1'b1; end
      `FUNC_SH:  begin dec_sz = 3'd2; dec_st = 1'b1; end
      `FUNC_SW:  begin dec_sz = 3'd4; dec_st = 1'b1; end
      default:   dec_sz = 3'd0;
    endcase
  end

  // Request classification.
  logic [IDX_W-1:0] req_idx;
  logic [1:0]       req_lane;
  logic [ADDR_W:0]  last_byte;
  logic             funct_ok;
  logic             in_range;
  logic             crossing;
  logic             trap;
  logic             bad;
  logic             accept;

  assign req_idx   = req_addr_i[IDX_W+1:2];
  assign req_lane  = req_addr_i[1:0];
  assign last_byte = {1'b0, req_addr_i} + (ADDR_W+1)'(dec_sz) - (ADDR_W+1)'(1);
  assign funct_ok  = (dec_sz != 3'd0) && (dec_st == req_we_i);
  assign in_range  = last_byte < (ADDR_W+1)'(MEM_BYTES);
  assign crossing  = (3'(req_lane) + dec_sz) > 3'd4;

`ifdef MISALIGN_TRAP_EN
  assign trap = ((dec_sz == 3'd2) && req_lane[0]) || ((dec_sz == 3'd4) && (req_lane != 2'd0));
`else
  assign trap = 1'b0;
`endif

  assign bad         = !funct_ok || !in_range || trap;
  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  // Store data and byte enables placed in a two-word window starting at the lane.
  logic [3:0]  st_mask;
  logic [63:0] st_shift;
  logic [7:0]  st_be;

  assign st_mask  = (dec_sz == 3'd1) ? 4'b0001 : (dec_sz == 3'd2) ? 4'b0011 : 4'b1111;
  assign st_shift = {32'h0, req_wdata_i} << {req_lane, 3'b000};
  assign st_be    = {4'h0, st_mask} << req_lane;

  // Read paths: first word at accept, following word in BEAT2.
  logic [IDX_W-1:0] idx_nxt;
  logic [31:0]      rd_lo;
  logic [31:0]      rd_hi;
  logic [31:0]      ld_one;
  logic [31:0]      ld_two;

  assign idx_nxt = idx_q + IDX_W'(1);
  assign rd_lo   = mem_q[req_idx] ^ image_word(req_idx);
  assign rd_hi   = mem_q[idx_nxt] ^ image_word(idx_nxt);
  assign ld_one  = rd_lo >> {req_lane, 3'b000};
  assign ld_two  = 32'({rd_hi, lo_q} >> {lane_q, 3'b000});

  // Write port.
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic [31:0]      wr_word;

  assign wr_word = wr_data ^ image_word(wr_idx);

  // Next-state, response and write-port control.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    sz_d        = sz_q;
    sx_d        = sx_q;
    we_d        = we_q;
    lo_d        = lo_q;
    hi_wdata_d  = hi_wdata_q;
    hi_be_d     = hi_be_q;
    wr_en       = 1'b0;
    wr_idx      = req_idx;
    wr_data     = st_shift[31:0];
    wr_be       = st_be[3:0];
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            wr_en = req_we_i;
            if (crossing) begin
              state_d    = S_BEAT2;
              idx_d      = req_idx;
              lane_d     = req_lane;
              sz_d       = dec_sz;
              sx_d       = dec_sx;
              we_d       = req_we_i;
              lo_d       = rd_lo;
              hi_wdata_d = st_shift[63:32];
              hi_be_d    = st_be[7:4];
            end else begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b0;
              rsp_rdata_d = req_we_i ? '0 : extend(ld_one, dec_sz, dec_sx);
            end
          end
        end
      end
      S_BEAT2: begin
        // Reset at this edge drops the high portion; the low portion stays written.
        state_d     = S_IDLE;
        wr_en       = we_q && !rst_i;
        wr_idx      = idx_nxt;
        wr_data     = hi_wdata_q;
        wr_be       = hi_be_q;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = we_q ? '0 : extend(ld_two, sz_q, sx_q);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      idx_q       <= '0;
      lane_q      <= '0;
      sz_q        <= '0;
      sx_q        <= 1'b0;
      we_q        <= 1'b0;
      lo_q        <= '0;
      hi_wdata_q  <= '0;
      hi_be_q     <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      sz_q        <= sz_d;
      sx_q        <= sx_d;
      we_q        <= we_d;
      lo_q        <= lo_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_be_q     <= hi_be_d;
    end
  end

  // Storage array, never reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_q[wr_idx][8*l +: 8] <= wr_word[8*l +: 8];
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: directed vectors plus a random mix
// checked against a byte-array reference model.

`ifndef FUNC_LB
`define FUNC_LB  10'b000_0000011
`endif
`ifndef FUNC_LH
`define FUNC_LH  10'b001_0000011
`endif
`ifndef FUNC_LW
`define FUNC_LW  10'b010_0000011
`endif
`ifndef FUNC_LBU
`define FUNC_LBU 10'b100_0000011
`endif
`ifndef FUNC_LHU
`define FUNC_LHU 10'b101_0000011
`endif
`ifndef FUNC_SB
`define FUNC_SB  10'b000_0100011
`endif
`ifndef FUNC_SH
`define FUNC_SH  10'b001_0100011
`endif
`ifndef FUNC_SW
`define FUNC_SW  10'b010_0100011
`endif

module tb_data_ram_ctrl;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned MEM_BYTES = 4 * DEPTH;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [9:0]        req_funct_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              rsp_valid_o;
  logic [31:0]       rsp_rdata_o;
  logic              rsp_err_o;

  always #5 clk_i = ~clk_i;

  data_ram_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_funct_i (req_funct_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic [7:0]  model [MEM_BYTES];
  logic [9:0]  func_tbl [8];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned fsize(input logic [9:0] f);
    case (f)
      `FUNC_LB, `FUNC_LBU, `FUNC_SB: return 1;
      `FUNC_LH, `FUNC_LHU, `FUNC_SH: return 2;
      `FUNC_LW, `FUNC_SW:            return 4;
      default:                       return 0;
    endcase
  endfunction

  function automatic logic fstore(input logic [9:0] f);
    return (f == `FUNC_SB) || (f == `FUNC_SH) || (f == `FUNC_SW);
  endfunction

  function automatic logic fsigned(input logic [9:0] f);
    return (f == `FUNC_LB) || (f == `FUNC_LH);
  endfunction

  // Compares every response pulse against the oldest expected entry.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        check_eq("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("rdata", rsp_rdata_o, e.rdata);
          check_eq("err", 32'(rsp_err_o), 32'(e.err));
          check_eq("latency", cyc, e.cyc);
        end
      end
    end
  endtask

  // Issues one request and queues its expected response.
  task automatic send(input logic we, input logic [9:0] f, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                      input int unsigned lat);
    int unsigned waited;
    int unsigned sz;
    waited = 0;
    @(negedge clk_i);
    while (!req_ready_o && waited < 8) begin
      @(negedge clk_i);
      waited++;
    end
    if (!req_ready_o) begin
      check_eq("ready_timeout", 32'(req_ready_o), 32'd1);
      return;
    end
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_funct_i = f;
    req_addr_i  = addr;
    req_wdata_i = wd;
    exp_q.push_back('{rdata: erd, err: eerr, cyc: cyc + lat});
    sz = fsize(f);
    if (we && !eerr) begin
      for (int unsigned k = 0; k < sz; k++) model[addr + k] = wd[8*k +: 8];
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Derives the expected response from the reference model, then issues it.
  task automatic send_model(input logic we, input logic [9:0] f, input logic [31:0] addr,
                            input logic [31:0] wd);
    int unsigned sz;
    logic        err;
    logic        mis;
    logic [31:0] rd;
    int unsigned lat;
    sz  = fsize(f);
    rd  = '0;
    mis = ((sz == 2) && addr[0]) || ((sz == 4) && (addr[1:0] != 2'd0));
    err = (sz == 0) || (fstore(f) != we) || ((64'(addr) + 64'(sz)) > 64'(MEM_BYTES));
`ifdef MISALIGN_TRAP_EN
    err = err || mis;
`endif
    lat = (!err && ((32'(addr[1:0]) + sz) > 4)) ? 2 : 1;
    if (!err && !we) begin
      for (int unsigned k = 0; k < sz; k++) rd[8*k +: 8] = model[addr + k];
      if (fsigned(f) && sz == 1 && rd[7])  rd[31:8]  = '1;
      if (fsigned(f) && sz == 2 && rd[15]) rd[31:16] = '1;
    end
    send(we, f, addr, wd, rd, err, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  f;
    logic        we;
    logic [31:0] a;
    func_tbl = '{`FUNC_LB, `FUNC_LH, `FUNC_LW, `FUNC_LBU, `FUNC_LHU,
                 `FUNC_SB, `FUNC_SH, `FUNC_SW};
    for (int unsigned i = 0; i < MEM_BYTES; i++) model[i] = (i < 32) ? 8'(i) : 8'h00;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_funct_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;

    fork
      monitor();
    join_none

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_valid", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rdata", rsp_rdata_o, 32'd0);
    check_eq("rst_err", 32'(rsp_err_o), 32'd0);
    check_eq("rst_ready", 32'(req_ready_o), 32'd0);
    rst_i = 1'b0;

`ifndef MISALIGN_TRAP_EN
    send(1'b0, `FUNC_LW, 32'h04, 32'h0, 32'h07060504, 1'b0, 1);
    send(1'b0, `FUNC_LB, 32'h1F, 32'h0, 32'h0000001F, 1'b0, 1);
    // Word-crossing store: one-cycle ready gap, two-cycle response.
    send(1'b1, `FUNC_SW, 32'h41, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    @(negedge clk_i);
    check_eq("split_ready_low", 32'(req_ready_o), 32'd0);
    send(1'b0, `FUNC_LW, 32'h40, 32'h0, 32'hADBEEF00, 1'b0, 1);
    send(1'b0, `FUNC_LW, 32'h44, 32'h0, 32'h000000DE, 1'b0, 1);
    send(1'b0, `FUNC_LH, 32'h43, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    send(1'b0, `FUNC_LHU, 32'h43, 32'h0, 32'h0000DEAD, 1'b0, 2);
    send(1'b0, `FUNC_LH, 32'h41, 32'h0, 32'hFFFFBEEF, 1'b0, 1);
    // Store then immediate load of the same byte.
    send(1'b1, `FUNC_SB, 32'h40, 32'h80, 32'h0, 1'b0, 1);
    send(1'b0, `FUNC_LB, 32'h40, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    send(1'b0, `FUNC_LBU, 32'h40, 32'h0, 32'h00000080, 1'b0, 1);
    // Range and funct errors.
    send(1'b0, `FUNC_LH, 32'h3FF, 32'h0, 32'h0, 1'b1, 1);
    send(1'b1, `FUNC_SH, 32'h3FF, 32'hAAAA, 32'h0, 1'b1, 1);
    send(1'b0, `FUNC_LB, 32'h3FF, 32'h0, 32'h0, 1'b0, 1);
    send(1'b0, 10'h3FF, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    send(1'b0, `FUNC_SW, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    // Reset asserted at the second-beat edge of a split store.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_funct_i = `FUNC_SW;
    req_addr_i  = 32'h81;
    req_wdata_i = 32'h11223344;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk_i);
    check_eq("abort_ready_low", 32'(req_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("abort_ready_back", 32'(req_ready_o), 32'd1);
    model[32'h81] = 8'h44;
    model[32'h82] = 8'h33;
    model[32'h83] = 8'h22;
    send(1'b0, `FUNC_LW, 32'h80, 32'h0, 32'h22334400, 1'b0, 1);
    send(1'b0, `FUNC_LB, 32'h84, 32'h0, 32'h0, 1'b0, 1);
`else
    send(1'b0, `FUNC_LW, 32'h2, 32'h0, 32'h0, 1'b1, 1);
    send(1'b0, `FUNC_LH, 32'h1, 32'h0, 32'h0, 1'b1, 1);
    send(1'b0, `FUNC_LW, 32'h0, 32'h0, 32'h03020100, 1'b0, 1);
    send(1'b1, `FUNC_SW, 32'h41, 32'hDEADBEEF, 32'h0, 1'b1, 1);
    send(1'b0, `FUNC_LW, 32'h40, 32'h0, 32'h0, 1'b0, 1);
    send(1'b0, `FUNC_LH, 32'h3FE, 32'h0, 32'h0, 1'b0, 1);
    send(1'b0, 10'h3FF, 32'h0, 32'h0, 32'h0, 1'b1, 1);
`endif

    // Random mix against the reference model.
    for (int i = 0; i < 80; i++) begin
      f  = ($urandom_range(0, 15) == 0) ? 10'h3FF : func_tbl[$urandom_range(0, 7)];
      we = fstore(f);
      if ($urandom_range(0, 9) == 0) we = !we;
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1016, 1100))
                                       : 32'($urandom_range(0, 1023));
      send_model(we, f, a, $urandom);
    end

    repeat (5) @(negedge clk_i);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
